// File: rtl/commit_trace_pkg.sv
// commit_trace_pkg: record layout and controller state encoding shared by
// commit_trace_buf and its record FIFO.
package commit_trace_pkg;

    // Record = {halt, mem_wr, mem_rd, reg_wr, reg[2:0], reg_data, addr, mem_data}
    localparam int REC_W        = 55;
    localparam int MEM_DATA_LSB = 0;
    localparam int ADDR_LSB     = 16;
    localparam int REG_DATA_LSB = 32;
    localparam int REG_LSB      = 48;
    localparam int REG_WR_BIT   = 51;
    localparam int MEM_RD_BIT   = 52;
    localparam int MEM_WR_BIT   = 53;
    localparam int HALT_BIT     = 54;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/commit_trace_buf_fifo.sv
// trace_fifo: synchronous FIFO holding captured commit records.
// A push into a full FIFO only lands when a pop frees a slot in the same
// cycle; otherwise the push is ignored (the caller accounts for the drop).
module trace_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 55
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);
    // Empty FIFO presents zero so the output is defined out of reset.
    assign rdata = empty ? '0 : mem_q[rd_ptr_q];

    // Next-state for storage, pointers (wrap naturally, DEPTH is 2^n) and occupancy.
    always_comb begin
        do_pop   = pop & ~empty;
        do_push  = push & (~full | do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; reset discards queued records.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Record storage, no reset needed since reads are masked when empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/commit_trace_buf.sv
// commit_trace_buf: captures per-cycle commit events into a record FIFO,
// tracks cycle/instruction/drop counters and sequences run -> drain -> done
// after a halt commit.
// Optional feature macro: CACHE_STATS_EN adds cache request/hit counters.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_RUN   | capturing commits, cycle counter running
// ST_DRAIN | halt seen, commits ignored, waiting for FIFO to empty
// ST_DONE  | FIFO drained after halt, held until reset
module commit_trace_buf
    import commit_trace_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cm_reg_wr,
    input  logic             cm_mem_rd,
    input  logic             cm_mem_wr,
    input  logic             cm_halt,
    input  logic [2:0]       cm_reg,
    input  logic [15:0]      cm_reg_data,
    input  logic [15:0]      cm_addr,
    input  logic [15:0]      cm_mem_data,
    output logic             rec_valid,
    input  logic             rec_ready,
    output logic [REC_W-1:0] rec_data,
    output logic             halted,
    output logic             done,
    output logic             overflow,
    output logic [CNT_W-1:0] drop_count,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] inst_count
`ifdef CACHE_STATS_EN
    ,
    input  logic             ic_req,
    input  logic             ic_hit,
    input  logic             dc_req,
    input  logic             dc_hit,
    output logic [CNT_W-1:0] icreq_count,
    output logic [CNT_W-1:0] ichit_count,
    output logic [CNT_W-1:0] dcreq_count,
    output logic [CNT_W-1:0] dchit_count
`endif
);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [CNT_W-1:0] cycle_q, cycle_d;
    logic [CNT_W-1:0] inst_q, inst_d;
    logic             ovf_q, ovf_d;
    logic             in_run, capture, pop, drop;
    logic             fifo_full, fifo_empty;
    logic [REC_W-1:0] rec_w;

    // Pack the sampled commit fields into one record.
    always_comb begin
        rec_w                           = '0;
        rec_w[HALT_BIT]                 = cm_halt;
        rec_w[MEM_WR_BIT]               = cm_mem_wr;
        rec_w[MEM_RD_BIT]               = cm_mem_rd;
        rec_w[REG_WR_BIT]               = cm_reg_wr;
        rec_w[REG_LSB +: 3]             = cm_reg;
        rec_w[REG_DATA_LSB +: 16]       = cm_reg_data;
        rec_w[ADDR_LSB +: 16]           = cm_addr;
        rec_w[MEM_DATA_LSB +: 16]       = cm_mem_data;
    end

    assign in_run    = (state_q == ST_RUN);
    assign capture   = in_run & (cm_reg_wr | cm_mem_rd | cm_mem_wr | cm_halt);
    assign rec_valid = ~fifo_empty;
    assign pop       = rec_valid & rec_ready;
    assign drop      = capture & fifo_full & ~pop;

    trace_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (REC_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (capture),
        .pop   (pop),
        .wdata (rec_w),
        .rdata (rec_data),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Halt sequencing; a dropped halt still ends the run.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (capture & cm_halt) state_d = ST_DRAIN;
            ST_DRAIN: if (fifo_empty)        state_d = ST_DONE;
            ST_DONE:  state_d = ST_DONE;
            default:  state_d = ST_RUN;
        endcase
    end

    // Saturating counters and sticky overflow.
    always_comb begin
        drop_d  = drop_q;
        cycle_d = cycle_q;
        inst_d  = inst_q;
        ovf_d   = ovf_q | drop;
        if (drop && drop_q != '1) begin
            drop_d = drop_q + 1'b1;
        end
        if (in_run && cycle_q != '1) begin
            cycle_d = cycle_q + 1'b1;
        end
        if (capture && (cm_halt | cm_reg_wr | cm_mem_wr) && inst_q != '1) begin
            inst_d = inst_q + 1'b1;
        end
    end

    // Controller registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            drop_q  <= '0;
            cycle_q <= '0;
            inst_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            drop_q  <= drop_d;
            cycle_q <= cycle_d;
            inst_q  <= inst_d;
            ovf_q   <= ovf_d;
        end
    end

    assign halted      = (state_q != ST_RUN);
    assign done        = (state_q == ST_DONE);
    assign overflow    = ovf_q;
    assign drop_count  = drop_q;
    assign cycle_count = cycle_q;
    assign inst_count  = inst_q;

`ifdef CACHE_STATS_EN
    logic [CNT_W-1:0] icreq_q, icreq_d, ichit_q, ichit_d;
    logic [CNT_W-1:0] dcreq_q, dcreq_d, dchit_q, dchit_d;

    // Cache event counters, active only while running, saturating.
    always_comb begin
        icreq_d = icreq_q;
        ichit_d = ichit_q;
        dcreq_d = dcreq_q;
        dchit_d = dchit_q;
        if (in_run && ic_req && icreq_q != '1) icreq_d = icreq_q + 1'b1;
        if (in_run && ic_hit && ichit_q != '1) ichit_d = ichit_q + 1'b1;
        if (in_run && dc_req && dcreq_q != '1) dcreq_d = dcreq_q + 1'b1;
        if (in_run && dc_hit && dchit_q != '1) dchit_d = dchit_q + 1'b1;
    end

    // Cache counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            icreq_q <= '0;
            ichit_q <= '0;
            dcreq_q <= '0;
            dchit_q <= '0;
        end else begin
            icreq_q <= icreq_d;
            ichit_q <= ichit_d;
            dcreq_q <= dcreq_d;
            dchit_q <= dchit_d;
        end
    end

    assign icreq_count = icreq_q;
    assign ichit_count = ichit_q;
    assign dcreq_count = dcreq_q;
    assign dchit_count = dchit_q;
`endif

endmodule

// File: tb/tb_commit_trace_buf.sv
// tb_commit_trace_buf: directed and randomized stimulus against a queue-based
// reference model of the commit trace buffer.
module tb_commit_trace_buf;

    localparam int DEPTH = 8;
    localparam int CW    = 8;
    localparam int SAT   = (1 << CW) - 1;

    logic          clk;
    logic          rst;
    logic          cm_reg_wr, cm_mem_rd, cm_mem_wr, cm_halt;
    logic [2:0]    cm_reg;
    logic [15:0]   cm_reg_data, cm_addr, cm_mem_data;
    logic          rec_valid, rec_ready;
    logic [54:0]   rec_data;
    logic          halted, done, overflow;
    logic [CW-1:0] drop_count, cycle_count, inst_count;
`ifdef CACHE_STATS_EN
    logic          ic_req, ic_hit, dc_req, dc_hit;
    logic [CW-1:0] icreq_count, ichit_count, dcreq_count, dchit_count;
    int            m_icreq, m_ichit, m_dcreq, m_dchit;
`endif

    commit_trace_buf #(.DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .cm_reg_wr(cm_reg_wr), .cm_mem_rd(cm_mem_rd), .cm_mem_wr(cm_mem_wr), .cm_halt(cm_halt),
        .cm_reg(cm_reg), .cm_reg_data(cm_reg_data), .cm_addr(cm_addr), .cm_mem_data(cm_mem_data),
        .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_data(rec_data),
        .halted(halted), .done(done), .overflow(overflow),
        .drop_count(drop_count), .cycle_count(cycle_count), .inst_count(inst_count)
`ifdef CACHE_STATS_EN
        , .ic_req(ic_req), .ic_hit(ic_hit), .dc_req(dc_req), .dc_hit(dc_hit),
        .icreq_count(icreq_count), .ichit_count(ichit_count),
        .dcreq_count(dcreq_count), .dchit_count(dchit_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [54:0] q[$];
    int  m_drop, m_cycle, m_inst;
    bit  m_ovf, m_halted, m_done;
    int  n_checks, n_err;

    function automatic int sat_inc(int v);
        return (v < SAT) ? v + 1 : v;
    endfunction

    // Advance the model by one clock using the inputs currently driven.
    function automatic void model_update();
        int sz;
        bit p, c, was_halted;
        if (rst) begin
            q.delete();
            m_drop = 0; m_cycle = 0; m_inst = 0;
            m_ovf = 0; m_halted = 0; m_done = 0;
`ifdef CACHE_STATS_EN
            m_icreq = 0; m_ichit = 0; m_dcreq = 0; m_dchit = 0;
`endif
            return;
        end
        sz = q.size();
        was_halted = m_halted;
        p = (sz > 0) && rec_ready;
        c = !was_halted && (cm_reg_wr || cm_mem_rd || cm_mem_wr || cm_halt);
        if (!was_halted) m_cycle = sat_inc(m_cycle);
`ifdef CACHE_STATS_EN
        if (!was_halted && ic_req) m_icreq = sat_inc(m_icreq);
        if (!was_halted && ic_hit) m_ichit = sat_inc(m_ichit);
        if (!was_halted && dc_req) m_dcreq = sat_inc(m_dcreq);
        if (!was_halted && dc_hit) m_dchit = sat_inc(m_dchit);
`endif
        if (was_halted && !m_done && sz == 0) m_done = 1;
        if (p) void'(q.pop_front());
        if (c) begin
            if (cm_halt || cm_reg_wr || cm_mem_wr) m_inst = sat_inc(m_inst);
            if (sz < DEPTH || p)
                q.push_back({cm_halt, cm_mem_wr, cm_mem_rd, cm_reg_wr, cm_reg,
                             cm_reg_data, cm_addr, cm_mem_data});
            else begin
                m_drop = sat_inc(m_drop);
                m_ovf  = 1;
            end
            if (cm_halt) m_halted = 1;
        end
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [54:0] e;
        e = (q.size() > 0) ? q[0] : 55'd0;
        chk("rec_valid", 64'(rec_valid), 64'(q.size() > 0));
        chk("rec_data", 64'(rec_data), 64'(e));
        chk("halted", 64'(halted), 64'(m_halted));
        chk("done", 64'(done), 64'(m_done));
        chk("overflow", 64'(overflow), 64'(m_ovf));
        chk("drop_count", 64'(drop_count), 64'(m_drop));
        chk("cycle_count", 64'(cycle_count), 64'(m_cycle));
        chk("inst_count", 64'(inst_count), 64'(m_inst));
`ifdef CACHE_STATS_EN
        chk("icreq_count", 64'(icreq_count), 64'(m_icreq));
        chk("ichit_count", 64'(ichit_count), 64'(m_ichit));
        chk("dcreq_count", 64'(dcreq_count), 64'(m_dcreq));
        chk("dchit_count", 64'(dchit_count), 64'(m_dchit));
`endif
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle();
        cm_reg_wr = 0; cm_mem_rd = 0; cm_mem_wr = 0; cm_halt = 0;
        cm_reg = 3'($urandom); cm_reg_data = 16'($urandom);
        cm_addr = 16'($urandom); cm_mem_data = 16'($urandom);
`ifdef CACHE_STATS_EN
        ic_req = 0; ic_hit = 0; dc_req = 0; dc_hit = 0;
`endif
    endtask

    task automatic do_reset();
        rst = 1;
        step();
        rst = 0;
    endtask

    task automatic rand_flags(input int halt_mod);
        cm_reg_wr = ($urandom_range(0, 2) == 0);
        cm_mem_rd = ($urandom_range(0, 2) == 0);
        cm_mem_wr = ($urandom_range(0, 2) == 0);
        cm_halt   = (halt_mod > 0) ? ($urandom_range(0, halt_mod - 1) == 0) : 1'b0;
        cm_reg = 3'($urandom); cm_reg_data = 16'($urandom);
        cm_addr = 16'($urandom); cm_mem_data = 16'($urandom);
`ifdef CACHE_STATS_EN
        ic_req = 1'($urandom); ic_hit = 1'($urandom);
        dc_req = 1'($urandom); dc_hit = 1'($urandom);
`endif
    endtask

    initial begin
        int pops, snap, waited;
        n_checks = 0; n_err = 0;
        rst = 1; rec_ready = 0;
        idle();

        // Reset with a commit pending: reset wins.
        cm_reg_wr = 1; rec_ready = 1;
        do_reset();
        idle(); rec_ready = 0;
        chk("reset_rec_data", 64'(rec_data), 64'd0);
        chk("reset_valid", 64'(rec_valid), 64'd0);

        // Single register write record.
        cm_reg_wr = 1; cm_reg = 3'd3; cm_reg_data = 16'h1234;
        cm_addr = 16'h0; cm_mem_data = 16'h0;
        step();
        idle();
        chk("single_valid", 64'(rec_valid), 64'd1);
        chk("single_rec", 64'(rec_data), 64'({4'b0001, 3'd3, 16'h1234, 16'h0, 16'h0}));
        chk("single_inst", 64'(inst_count), 64'd1);

        // Ten stores into an 8-deep FIFO with no consumer.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            idle(); cm_mem_wr = 1;
            step();
        end
        idle();
        chk("ovf_drop", 64'(drop_count), 64'd2);
        chk("ovf_flag", 64'(overflow), 64'd1);
        chk("ovf_inst", 64'(inst_count), 64'd10);

        // Full FIFO, capture with simultaneous pop, then drain everything.
        cm_mem_wr = 1; rec_ready = 1;
        step();
        chk("full_pop_drop", 64'(drop_count), 64'd2);
        idle();
        pops = 0;
        for (int i = 0; i < 20 && rec_valid; i++) begin
            step();
            pops++;
        end
        chk("full_pop_count", 64'(pops), 64'd8);
        rec_ready = 0;

        // Two loads, a halt, then drain with ignored register writes.
        do_reset();
        for (int i = 0; i < 2; i++) begin
            idle(); cm_mem_rd = 1;
            step();
        end
        idle(); cm_halt = 1;
        step();
        chk("halt_halted", 64'(halted), 64'd1);
        snap = int'(cycle_count);
        idle(); cm_reg_wr = 1; rec_ready = 1;
        waited = 0;
        while (!done && waited < 20) begin
            step();
            waited++;
        end
        chk("halt_done_in_time", 64'(done), 64'd1);
        chk("halt_cycle_frozen", 64'(cycle_count), 64'(snap));
        chk("halt_inst", 64'(inst_count), 64'd1);
        for (int i = 0; i < 3; i++) step();
        chk("done_hold", 64'(done), 64'd1);

        // Reset while draining with three records queued.
        idle(); rec_ready = 0;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            idle(); cm_mem_rd = 1;
            step();
        end
        idle(); cm_halt = 1;
        step();
        idle();
        chk("drain_halted", 64'(halted), 64'd1);
        cm_reg_wr = 1; rec_ready = 1;
        do_reset();
        idle(); rec_ready = 0;
        chk("rst_drain_valid", 64'(rec_valid), 64'd0);
        chk("rst_drain_halted", 64'(halted), 64'd0);
        chk("rst_drain_cycle", 64'(cycle_count), 64'd0);

        // Long random run without halts: counters reach saturation.
        for (int i = 0; i < 300; i++) begin
            rand_flags(0);
            rec_ready = ($urandom_range(0, 3) == 0);
            step();
        end
        idle();
        chk("cycle_saturated", 64'(cycle_count), 64'(SAT));

        // Random run with halts and occasional resets.
        do_reset();
        for (int i = 0; i < 800; i++) begin
            rand_flags(40);
            rec_ready = 1'($urandom);
            rst = (m_done && $urandom_range(0, 3) == 0) || ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 0;
        idle();

`ifdef CACHE_STATS_EN
        do_reset();
        for (int i = 0; i < 5; i++) begin
            idle(); ic_req = 1; ic_hit = (i < 3);
            step();
        end
        idle();
        chk("icreq_five", 64'(icreq_count), 64'd5);
        chk("ichit_three", 64'(ichit_count), 64'd3);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
